// File: rtl/spr_issue_arbiter_pkg.sv
// Shared definitions for the SPR issue arbiter: default sizing and FSM state type.
// Optional feature macro used by the top level: SPR_ARB_AGING_EN.
package spr_issue_arbiter_pkg;

   // Global CU geometry
   localparam int unsigned WF_PER_CU    = 40;
   localparam int unsigned WF_ID_LENGTH = 6;

   // Arbiter defaults
   localparam int unsigned ARB_NUM_WF       = WF_PER_CU;
   localparam int unsigned ARB_WFID_W       = WF_ID_LENGTH;
   localparam int unsigned ARB_HOLDOFF      = 2;
   localparam int unsigned ARB_STARVE_LIMIT = 15;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_OFFER = 1'b1
   } arb_state_e;

endpackage

// File: rtl/spr_issue_arbiter_picker.sv
// rr_priority_picker: first set request bit at or above the pointer, wrapping
// from N-1 back to 0. Purely combinational.
module rr_priority_picker #(
   parameter int unsigned N     = 40,
   parameter int unsigned IDX_W = 6
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic             found_o,
   output logic [IDX_W-1:0] idx_o
);

   // Rotating scan starting at the pointer
   always_comb begin
      int unsigned k;
      logic        hit;
      k       = 0;
      hit     = 1'b0;
      idx_o   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         k = 32'(ptr_i) + i;
         if (k >= N) k = k - N;
         if (!hit && req_i[k]) begin
            hit   = 1'b1;
            idx_o = IDX_W'(k);
         end
      end
      found_o = hit;
   end

endmodule

// File: rtl/spr_issue_arbiter.sv
// spr_issue_arbiter: round-robin issue scheduler between the SPR dependency
// table and the ALU/LSU issue ports, with per-wavefront hold-off after issue.
// Optional starvation aging is enabled by defining SPR_ARB_AGING_EN.
module spr_issue_arbiter
   import spr_issue_arbiter_pkg::*;
#(
   parameter int unsigned NUM_WF       = ARB_NUM_WF,
   parameter int unsigned WFID_W       = ARB_WFID_W,
   parameter int unsigned HOLDOFF      = ARB_HOLDOFF,
   parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_WF-1:0] ready_arry_spr,
   input  logic [NUM_WF-1:0] ready_arry_opnd,
   input  logic [NUM_WF-1:0] wf_valid,
   input  logic              flush_valid,
   input  logic [WFID_W-1:0] flush_wfid,
   input  logic              issue_ready,
   output logic              issue_valid,
   output logic [WFID_W-1:0] issued_wfid
);

   localparam int unsigned HOLD_W = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);

   arb_state_e        state_q;
   logic [WFID_W-1:0] wfid_q;
   logic [WFID_W-1:0] ptr_q;
   logic [HOLD_W-1:0] hold_q [NUM_WF];

   logic [NUM_WF-1:0] cand;
   logic              rr_found;
   logic [WFID_W-1:0] rr_idx;
   logic              sel_found;
   logic [WFID_W-1:0] sel_idx;
   logic              accept;
   logic              flush_offer;

   assign issue_valid = (state_q == ST_OFFER);
   assign issued_wfid = wfid_q;
   assign accept      = (state_q == ST_OFFER) && issue_ready;
   assign flush_offer = (state_q == ST_OFFER) && flush_valid && (flush_wfid == wfid_q);

   // Eligible wavefronts: fully ready, not held off, not already offered, not being flushed
   always_comb begin
      cand = '0;
      for (int unsigned w = 0; w < NUM_WF; w++) begin
         cand[w] = ready_arry_spr[w] & ready_arry_opnd[w] & wf_valid[w]
                 & (hold_q[w] == '0)
                 & !((state_q == ST_OFFER) && (wfid_q == WFID_W'(w)))
                 & !(flush_valid && (flush_wfid == WFID_W'(w)));
      end
   end

   rr_priority_picker #(
      .N     (NUM_WF),
      .IDX_W (WFID_W)
   ) u_rr_pick (
      .req_i   (cand),
      .ptr_i   (ptr_q),
      .found_o (rr_found),
      .idx_o   (rr_idx)
   );

`ifdef SPR_ARB_AGING_EN
   localparam int unsigned AGE_W = 4;

   logic [AGE_W-1:0]  age_q [NUM_WF];
   logic [NUM_WF-1:0] starving;
   logic              old_found;
   logic [WFID_W-1:0] old_idx;

   // Candidates that have waited at least the starvation threshold
   always_comb begin
      starving = '0;
      for (int unsigned w = 0; w < NUM_WF; w++) begin
         starving[w] = cand[w] && (32'(age_q[w]) >= STARVE_LIMIT);
      end
   end

   // Pointer fixed at zero gives lowest-id-first among starving wavefronts
   rr_priority_picker #(
      .N     (NUM_WF),
      .IDX_W (WFID_W)
   ) u_age_pick (
      .req_i   (starving),
      .ptr_i   ('0),
      .found_o (old_found),
      .idx_o   (old_idx)
   );

   assign sel_found = rr_found;
   assign sel_idx   = old_found ? old_idx : rr_idx;

   // Saturating per-wavefront age, cleared on accept or flush
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned w = 0; w < NUM_WF; w++) age_q[w] <= '0;
      end else begin
         for (int unsigned w = 0; w < NUM_WF; w++) begin
            if ((flush_valid && (flush_wfid == WFID_W'(w))) ||
                (accept && (wfid_q == WFID_W'(w)))) begin
               age_q[w] <= '0;
            end else if (cand[w] && (age_q[w] != '1)) begin
               age_q[w] <= age_q[w] + 1'b1;
            end
         end
      end
   end
`else
   assign sel_found = rr_found;
   assign sel_idx   = rr_idx;

   // Threshold only matters when aging is built in
   if (STARVE_LIMIT == 0) begin : g_no_aging
   end
`endif

   // Offer FSM: IDLE/OFFER with registered valid and id, pointer advances on accept
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         wfid_q  <= '0;
         ptr_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (sel_found) begin
                  state_q <= ST_OFFER;
                  wfid_q  <= sel_idx;
               end
            end
            ST_OFFER: begin
               if (issue_ready) begin
                  ptr_q <= (wfid_q == WFID_W'(NUM_WF - 1)) ? '0 : wfid_q + 1'b1;
                  if (sel_found) begin
                     wfid_q <= sel_idx;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end else if (flush_offer) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Hold-off counters: loaded on accept, count down to zero; flush has the last word
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned w = 0; w < NUM_WF; w++) hold_q[w] <= '0;
      end else begin
         for (int unsigned w = 0; w < NUM_WF; w++) begin
            if (flush_valid && (flush_wfid == WFID_W'(w))) begin
               hold_q[w] <= '0;
            end else if (accept && (wfid_q == WFID_W'(w))) begin
               hold_q[w] <= HOLD_W'(HOLDOFF);
            end else if (hold_q[w] != '0) begin
               hold_q[w] <= hold_q[w] - 1'b1;
            end
         end
      end
   end

endmodule
